// File: rtl/step3_normalize_round.sv
// Normalize, round-to-nearest-even and pack the adder's raw significand sum into an IEEE-754 word.
// Latency 3 cycles, one result per clock, no backpressure (never stalls).
module step3_normalize_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    in_valid,
    input  logic                    in_sign_in1,
    input  logic                    in_sign_in2,
    input  logic                    in_res_neg,
    input  logic [EXP_W-1:0]        in_current_ex,
    input  logic [FRAC_W+4:0]       in_mant_sum,
    output logic                    out_valid,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_zero,
    output logic                    out_overflow,
    output logic                    out_underflow
);

    localparam int MW  = FRAC_W + 5;
    localparam int SW  = FRAC_W + 1;
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(MW);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);

    // ---------------- stage 1: capture, sign select, leading-zero count
    logic                 s1_valid_q, s1_sign_q, s1_zero_q;
    logic                 s1_sign_d, s1_zero_d;
    logic [LZW-1:0]       s1_lz_q, s1_lz_d;
    logic [EXP_W-1:0]     s1_ex_q;
    logic [MW-1:0]        s1_mant_q;

    always_comb begin
        s1_sign_d = in_res_neg ? in_sign_in2 : in_sign_in1;
        s1_zero_d = (in_mant_sum == '0);
        // Count covers significand+GRS only; the highest set bit wins the loop.
        s1_lz_d   = LZW'(MW - 1);
        for (int i = 0; i < MW - 1; i++) begin
            if (in_mant_sum[i]) s1_lz_d = LZW'(MW - 2 - i);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_lz_q    <= '0;
            s1_ex_q    <= '0;
            s1_mant_q  <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= s1_sign_d;
            s1_zero_q  <= s1_zero_d;
            s1_lz_q    <= s1_lz_d;
            s1_ex_q    <= in_current_ex;
            s1_mant_q  <= in_mant_sum;
        end
    end

    // ---------------- stage 2: normalize and exponent adjust
    logic                 s2_valid_q, s2_sign_q, s2_zero_q, s2_unf_q;
    logic                 s2_unf_d;
    logic [MW-2:0]        s2_norm_q, s2_norm_d;
    logic signed [EW-1:0] s2_exp_q, s2_exp_d;
    logic signed [EW-1:0] ex_ext, lz_ext;

    always_comb begin
        ex_ext = $signed({2'b00, s1_ex_q});
        lz_ext = $signed({{(EW - LZW){1'b0}}, s1_lz_q});
        if (s1_mant_q[MW-1]) begin
            // Carry out: drop one bit to the right, folding it into sticky.
            s2_norm_d = {s1_mant_q[MW-1:2], |s1_mant_q[1:0]};
            s2_exp_d  = ex_ext + EXP_ONE;
        end else begin
            s2_norm_d = s1_mant_q[MW-2:0] << s1_lz_q;
            s2_exp_d  = ex_ext - lz_ext;
        end
        s2_unf_d = !s1_zero_q && (s2_exp_d <= EXP_ZERO);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_unf_q   <= 1'b0;
            s2_norm_q  <= '0;
            s2_exp_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_zero_q  <= s1_zero_q;
            s2_unf_q   <= s2_unf_d;
            s2_norm_q  <= s2_norm_d;
            s2_exp_q   <= s2_exp_d;
        end
    end

    // ---------------- stage 3: round to nearest even, classify, pack
    logic [SW-1:0]          sig;
    logic                   g_bit, r_bit, s_bit, inc;
    logic [SW:0]            rsum;
    logic [FRAC_W-1:0]      frac_f;
    logic signed [EW-1:0]   exp_f;
    logic                   out_valid_q, out_zero_q, out_ovf_q, out_unf_q;
    logic                   out_zero_d, out_ovf_d, out_unf_d;
    logic [EXP_W+FRAC_W:0]  out_res_q, out_res_d;

    always_comb begin
        sig    = s2_norm_q[MW-2:3];
        g_bit  = s2_norm_q[2];
        r_bit  = s2_norm_q[1];
        s_bit  = s2_norm_q[0];
        inc    = g_bit & (r_bit | s_bit | sig[0]);
        rsum   = {1'b0, sig} + {{SW{1'b0}}, inc};
        // Rounding carry means the significand became 10.00..0; renormalize.
        frac_f = rsum[SW] ? rsum[SW-1:1] : rsum[SW-2:0];
        exp_f  = s2_exp_q + (rsum[SW] ? EXP_ONE : EXP_ZERO);

        out_zero_d = 1'b0;
        out_ovf_d  = 1'b0;
        out_unf_d  = 1'b0;
        out_res_d  = {s2_sign_q, exp_f[EXP_W-1:0], frac_f};
        if (s2_zero_q) begin
            out_zero_d = 1'b1;
            out_res_d  = '0;
        end else if (s2_unf_q) begin
            out_unf_d = 1'b1;
            out_res_d = {s2_sign_q, {(EXP_W + FRAC_W){1'b0}}};
        end else if (exp_f >= EXP_MAX) begin
            out_ovf_d = 1'b1;
            out_res_d = {s2_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
            out_res_q   <= '0;
        end else begin
            out_valid_q <= s2_valid_q;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
            out_res_q   <= out_res_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_res_q;
    assign out_zero      = out_zero_q;
    assign out_overflow  = out_ovf_q;
    assign out_underflow = out_unf_q;

endmodule

// File: tb/tb_step3_normalize_round.sv
// Directed-vector bench for step3_normalize_round: single results, streaming pattern, mid-flight reset.
module tb_step3_normalize_round;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_sign_in1, in_sign_in2, in_res_neg;
    logic [7:0]  in_current_ex;
    logic [27:0] in_mant_sum;
    logic        out_valid;
    logic [31:0] out_result;
    logic        out_zero, out_overflow, out_underflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    step3_normalize_round dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_sign_in1   (in_sign_in1),
        .in_sign_in2   (in_sign_in2),
        .in_res_neg    (in_res_neg),
        .in_current_ex (in_current_ex),
        .in_mant_sum   (in_mant_sum),
        .out_valid     (out_valid),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One isolated valid; result must show exactly 3 edges later for one cycle.
    // flags = {zero, overflow, underflow}
    task automatic run_vec(input string tag, input logic [7:0] ex, input logic [27:0] mant,
                           input logic s1, input logic s2, input logic rn,
                           input logic [31:0] exp_res, input logic [2:0] flags);
        in_current_ex = ex;
        in_mant_sum   = mant;
        in_sign_in1   = s1;
        in_sign_in2   = s2;
        in_res_neg    = rn;
        in_valid      = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        step();
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, out_result, exp_res);
        chk({tag, "_flg"}, {29'd0, out_zero, out_overflow, out_underflow}, {29'd0, flags});
        step();
        chk({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [10:0] pat;
        resetn        = 1'b0;
        in_valid      = 1'b0;
        in_sign_in1   = 1'b0;
        in_sign_in2   = 1'b0;
        in_res_neg    = 1'b0;
        in_current_ex = 8'd0;
        in_mant_sum   = 28'd0;
        step();
        step();
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_res", out_result, 32'd0);
        chk("rst_flg", {29'd0, out_zero, out_overflow, out_underflow}, 32'd0);
        resetn = 1'b1;
        step();

        run_vec("one_plus_one", 8'd127, 28'h8000000, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b000);
        run_vec("cancel_pos",   8'd127, 28'h2000000, 1'b0, 1'b1, 1'b0, 32'h3F000000, 3'b000);
        run_vec("cancel_neg",   8'd127, 28'h2000000, 1'b0, 1'b1, 1'b1, 32'hBF000000, 3'b000);
        // significand 0x800001 with GRS=100: tie, odd LSB rounds up
        run_vec("tie_odd",      8'd127, 28'h400000C, 1'b0, 1'b0, 1'b0, 32'h3F800002, 3'b000);
        run_vec("tie_even",     8'd127, 28'h4000004, 1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b000);
        run_vec("above_half",   8'd127, 28'h4000005, 1'b0, 1'b0, 1'b0, 32'h3F800001, 3'b000);
        // significand 0xFFFFFF, GRS=110: rounding carries into a new exponent
        run_vec("round_carry",  8'd127, 28'h7FFFFFE, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b000);
        run_vec("zero",         8'd127, 28'h0000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 3'b100);
        run_vec("overflow",     8'd254, 28'h8000000, 1'b1, 1'b0, 1'b0, 32'hFF800000, 3'b010);
        run_vec("underflow",    8'd2,   28'h0200000, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b001);
        run_vec("underflow_ng", 8'd2,   28'h0200000, 1'b1, 1'b0, 1'b0, 32'h80000000, 3'b001);

        // Streaming: 10 valids with one gap; 1.0 significand, exponent tags each slot.
        pat = 11'b11111011111;
        for (int t = 0; t < 16; t++) begin
            if (t >= 3 && t - 3 < 11) begin
                chk($sformatf("stream_vld_%0d", t - 3), {31'd0, out_valid}, {31'd0, pat[t-3]});
                if (pat[t-3])
                    chk($sformatf("stream_res_%0d", t - 3), out_result, (32'd100 + 32'(t - 3)) << 23);
            end else if (t >= 14) begin
                chk($sformatf("stream_tail_%0d", t), {31'd0, out_valid}, 32'd0);
            end
            in_sign_in1   = 1'b0;
            in_res_neg    = 1'b0;
            in_mant_sum   = 28'h4000000;
            in_current_ex = 8'(100 + t);
            in_valid      = (t < 11) ? pat[t] : 1'b0;
            step();
        end

        // Reset while three results are in flight: none may ever appear.
        for (int t = 0; t < 3; t++) begin
            in_current_ex = 8'(50 + t);
            in_valid      = 1'b1;
            if (t == 2) resetn = 1'b0;
            step();
        end
        resetn   = 1'b1;
        in_valid = 1'b0;
        chk("flush_res", out_result, 32'd0);
        for (int t = 0; t < 6; t++) begin
            chk($sformatf("flush_vld_%0d", t), {31'd0, out_valid}, 32'd0);
            step();
        end

        run_vec("post_reset", 8'd127, 28'h8000000, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
